// File: rtl/mul_share_pkg.sv
// Shared types, sizes and the reference Q1.(MUL_W-1) multiply used by mul_share_arb and its bench.
package mul_share_pkg;

  localparam int NUM_REQ = 2;
  localparam int MUL_W   = 8;

  typedef logic req_id_t;

  // Wrapping fractional product: only (-1)*(-1) overflows, landing on the most negative code.
  function automatic logic [MUL_W-1:0] frac_mul(input logic [MUL_W-1:0] a,
                                                input logic [MUL_W-1:0] b);
    logic signed [2*MUL_W-1:0] full;
    full = (2*MUL_W)'($signed(a)) * (2*MUL_W)'($signed(b));
    return MUL_W'(full >>> (MUL_W-1));
  endfunction

endpackage

// File: rtl/mult2s.sv
// Combinational N-bit two's-complement fractional multiplier, Q1.(N-1) in and out, wrapping.
module mult2s #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  logic signed [2*N-1:0] full;

  always_comb begin
    full = (2*N)'($signed(a)) * (2*N)'($signed(b));
    p    = N'(full >>> (N-1));
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one mult2s between two requesters, with global stall.
// Define MUL_PIPE_EN to register operands ahead of the multiplier (latency 2 instead of 1).
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int N = MUL_W
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         stall,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp_data
);

  logic [NUM_REQ-1:0] valid_vec, ready_vec, hs_vec;
  req_id_t            ptr_q, ptr_d;
  req_id_t            winner;
  req_id_t            hs_id;
  logic               hs;
  logic [N-1:0]       sel_a, sel_b;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid_vec = {req1_valid, req0_valid};
    winner    = ptr_q;
    if (valid_vec == 2'b01)      winner = 1'b0;
    else if (valid_vec == 2'b10) winner = 1'b1;

    ready_vec = '0;
    if (!stall && nReset) ready_vec[winner] = 1'b1;

    hs_vec = valid_vec & ready_vec;
    hs     = |hs_vec;
    hs_id  = hs_vec[1];
    sel_a  = hs_id ? req1_a : req0_a;
    sel_b  = hs_id ? req1_b : req0_b;
    ptr_d  = hs ? ~hs_id : ptr_q;
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  logic [N-1:0] mul_a, mul_b, prod;
  logic         stage_valid;
  req_id_t      stage_tag;

`ifdef MUL_PIPE_EN
  logic         iss_valid_q, iss_valid_d;
  req_id_t      iss_tag_q, iss_tag_d;
  logic [N-1:0] iss_a_q, iss_a_d, iss_b_q, iss_b_d;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_tag_d   = iss_tag_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    if (!stall) begin
      iss_valid_d = hs;
      if (hs) begin
        iss_tag_d = hs_id;
        iss_a_d   = sel_a;
        iss_b_d   = sel_b;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      iss_valid_q <= 1'b0;
      iss_tag_q   <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_tag_q   <= iss_tag_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
    end
  end

  assign mul_a       = iss_a_q;
  assign mul_b       = iss_b_q;
  assign stage_valid = iss_valid_q;
  assign stage_tag   = iss_tag_q;
`else
  assign mul_a       = sel_a;
  assign mul_b       = sel_b;
  assign stage_valid = hs;
  assign stage_tag   = hs_id;
`endif

  mult2s #(.N(N)) u_mult2s (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  logic         out_valid_q, out_valid_d;
  req_id_t      out_tag_q, out_tag_d;
  logic [N-1:0] out_data_q, out_data_d;

  // A stalled output stage keeps its result so it is presented once stall drops.
  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    if (!stall) begin
      out_valid_d = stage_valid;
      if (stage_valid) begin
        out_tag_d  = stage_tag;
        out_data_d = prod;
      end
    end
  end

  // NOTE: data registers are reset too, because rsp_data must read zero out of reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rsp0_valid = out_valid_q & (out_tag_q == 1'b0) & ~stall;
  assign rsp1_valid = out_valid_q & (out_tag_q == 1'b1) & ~stall;
  assign rsp_data   = out_data_q;

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and issue sequencer that shares one N-bit two's-complement fractional multiplier (the `mult2s` datapath, Q1.(N-1) format) between two requesters, e.g. the ALU execute stage and the address/immediate-scaling unit. It accepts at most one operand pair per cycle over a valid/ready handshake and routes each registered product back to the requester that issued it. A global `stall` freezes the pipeline without losing or duplicating results. Fixed pipeline depth; the response path has no backpressure.

## Interface
- `N`, 8, operand and result width (Q1.(N-1) fractional).
- `clk`  in  1  rising-edge clock.
- `nReset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  freezes the issue and result pipeline.
- `req0_valid`, `req1_valid`  in  1  requester i has an operand pair.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  N  signed operands.
- `req0_ready`, `req1_ready`  out  1  grant; handshake when valid & ready.
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle result strobe for requester i.
- `rsp_data`  out  N  shared result bus, valid when either `rsp*_valid` is high.

## Operation
- Grant is combinational: `reqX_ready` = winner & ~`stall`. At most one ready per cycle. Ready never depends on the requester's own valid being low.
- Round-robin state is a 1-bit priority pointer. After reset, priority is requester 0.
  - Both valid: grant the priority holder.
  - One valid: grant it regardless of priority.
  - After any handshake to i, the pointer moves to the other requester.
  - The pointer does not change on cycles without a handshake.
- On handshake, capture a, b and a 1-bit tag (requester index) into the issue stage with stage valid = 1. Otherwise stage valid = 0 unless stalled.
- Product: `result = ((sext(a) * sext(b)) >> (N-1))[N-1:0]`, wrapping with no saturation.
  - Only (-1)·(-1) overflows; it returns 0x80 for N=8.
- Output stage holds the registered result, valid and tag.
  - `rsp_data` = result.
  - `rspX_valid` = out_valid & (tag == X) & ~`stall`.
- `stall` high:
  - Both readys are low.
  - Every pipeline register and the pointer hold.
  - Both `rsp*_valid` are low.
  - A result held in the output stage is presented on the first cycle after `stall` falls, exactly once.
- No back-to-back restriction: one issue per cycle at full throughput, alternating when both requesters are continuously valid.

## Timing
- Reset values: `req*_ready` 0 while `nReset` is low; `rsp0_valid` 0, `rsp1_valid` 0, `rsp_data` 0, pointer = 0.
  - All stage valids clear immediately (asynchronously).
- Latency, handshake edge to `rspX_valid` high: 1 cycle by default, 2 cycles with `MUL_PIPE_EN`. This excludes stalled cycles, which add 1:1.
- Reset asserted mid-operation: in-flight results are discarded and no response is emitted for them.
- Simultaneous handshake and result return for the same requester is legal. They are independent.
- Initiation interval is 1 in both configurations.

## Configuration
- `MUL_PIPE_EN` defined: operands are registered in the issue stage, the product is computed from the registered operands, and the product is registered in the output stage. Latency is 2 and the critical path is multiplier-only.
- `MUL_PIPE_EN` undefined: the product is computed directly from the handshaked operands and registered in the output stage. There is no separate issue stage and latency is 1.
- Arbitration, stall and reset behaviour are identical in both configurations.

## Structure
- Package `mul_share_pkg`:
  - `req_id_t` (1-bit tag typedef).
  - `NUM_REQ = 2`.
  - Function `frac_mul(a, b)` defining the reference arithmetic for RTL and bench.
- Sub-module: instantiate existing `mult2s #(N)` for the product.
- Arbitration and pipeline registers stay in `mul_share_arb`. No separate FSM module is needed: the pointer plus stage valids are the full state.

## Test plan
- After reset, both requesters valid: req0 gets 0x40·0x40 and req1 gets 0xC0·0x40. Then `rsp0_valid` with 0x20 and `rsp1_valid` with 0xE0, in successive cycles at the configured latency; grant order is 0, 1, 0, 1.
- req0 alone, valid on 4 consecutive cycles: 4 grants to req0 and 4 consecutive `rsp0_valid` strobes in order; `rsp1_valid` never asserts.
- Issue 0x80·0x80 from req1: `rsp_data` = 0x80 with `rsp1_valid` (wrap, no saturation). Also 0x7F·0x7F gives 0x7E.
- Hold `stall` for 3 cycles starting the cycle a result is due: no `rsp*_valid` and no ready during the stall. The result appears exactly once on the cycle after `stall` falls, and the pointer is unchanged.
- Drop `nReset` with 2 results in flight: all outputs go to 0 at once, no late responses, and after release req0 has priority.
- Random valid traffic for 10k cycles: every handshake yields exactly one correctly tagged response equal to `frac_mul`. Neither requester waits more than 1 cycle while continuously valid (barring stall).
